// File: rtl/hsv_core_reg_file.sv
// hsv core integer register file: x1..x31 flops, x0 reads as zero.
// Ports: clk_core, rst (async high); rs1/rs2 comb reads; one sync write.
// Optional define HSV_CORE_REGFILE_BYPASS_EN forwards wr_data to reads.

package hsv_core_pkg;
    typedef logic [31:0] word;
    typedef logic [4:0]  reg_addr;
endpackage

module hsv_core_reg_file
    import hsv_core_pkg::*;
(
    input  logic    clk_core,
    input  logic    rst,
    input  reg_addr rs1_addr,
    input  reg_addr rs2_addr,
    input  reg_addr wr_addr,
    input  word     wr_data,
    input  logic    wr_en,
    output word     rs1_data,
    output word     rs2_data
);

    word regs [1:31];

    logic wr_hit;
    assign wr_hit = wr_en && (wr_addr != '0);

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    reg_addr rd_addr [2];
    word     rd_data [2];

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    // rst gates the outputs so the bypass path cannot leak during reset.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (!rst && rd_addr[p] != '0) begin
`ifdef HSV_CORE_REGFILE_BYPASS_EN
                if (wr_hit && wr_addr == rd_addr[p]) begin
                    rd_data[p] = wr_data;
                end else begin
                    rd_data[p] = regs[rd_addr[p]];
                end
`else
                rd_data[p] = regs[rd_addr[p]];
`endif
            end
        end
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];

endmodule

// File: tb/tb_hsv_core_reg_file.sv
// Directed bench for hsv_core_reg_file.
// Inputs change on falling edges; reads are sampled between edges.

module tb_hsv_core_reg_file;
    import hsv_core_pkg::*;

    logic    clk_core = 1'b0;
    logic    rst;
    reg_addr rs1_addr, rs2_addr, wr_addr;
    word     wr_data;
    logic    wr_en;
    word     rs1_data, rs2_data;

    int checks = 0;
    int errors = 0;
    word fill [1:31];

    hsv_core_reg_file dut (
        .clk_core(clk_core),
        .rst(rst),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data)
    );

    always #5 clk_core = ~clk_core;

    task automatic chk(input string tag, input word got, input word exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wr(input reg_addr a, input word d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk_core);
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input reg_addr a1, input reg_addr a2,
                      input word e1, input word e2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
        chk({tag, "_rs1"}, rs1_data, e1);
        chk({tag, "_rs2"}, rs2_data, e2);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h7777_7777;
        rs1_addr = 5'd7;
        rs2_addr = 5'd31;
        #1;
        chk("rst_out1", rs1_data, 32'h0);
        chk("rst_out2", rs2_data, 32'h0);
        @(negedge clk_core);
        @(negedge clk_core);
        wr_en = 1'b0;
        rst = 1'b0;

        rd("rst_a0", 5'd0, 5'd0, 32'h0, 32'h0);
        rd("rst_a1", 5'd1, 5'd31, 32'h0, 32'h0);
        rd("rst_a7", 5'd7, 5'd1, 32'h0, 32'h0);

        wr(5'd3, 32'hDEAD_BEEF);
        wr(5'd15, 32'hCAFE_BABE);
        rd("dual", 5'd3, 5'd15, 32'hDEAD_BEEF, 32'hCAFE_BABE);
        rd("same", 5'd15, 5'd15, 32'hCAFE_BABE, 32'hCAFE_BABE);
        rd("swap", 5'd15, 5'd3, 32'hCAFE_BABE, 32'hDEAD_BEEF);

        wr(5'd0, 32'hFFFF_FFFF);
        rd("x0", 5'd0, 5'd0, 32'h0, 32'h0);
        rd("x0_side", 5'd3, 5'd15, 32'hDEAD_BEEF, 32'hCAFE_BABE);

        wr_en = 1'b0;
        wr_addr = 5'd3;
        wr_data = 32'h1234_5678;
        repeat (3) @(negedge clk_core);
        rd("gate", 5'd3, 5'd15, 32'hDEAD_BEEF, 32'hCAFE_BABE);

        wr(5'd5, 32'h1111_1111);
        rs1_addr = 5'd5;
        rs2_addr = 5'd3;
        wr_en = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hA5A5_A5A5;
        #1;
`ifdef HSV_CORE_REGFILE_BYPASS_EN
        chk("haz_pre", rs1_data, 32'hA5A5_A5A5);
`else
        chk("haz_pre", rs1_data, 32'h1111_1111);
`endif
        chk("haz_other", rs2_data, 32'hDEAD_BEEF);
        @(posedge clk_core);
        #1;
        wr_en = 1'b0;
        chk("haz_post", rs1_data, 32'hA5A5_A5A5);

        @(negedge clk_core);
        rs1_addr = 5'd0;
        wr_en = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'h5555_AAAA;
        #1;
        chk("x0_nofwd", rs1_data, 32'h0);
        @(negedge clk_core);
        wr_en = 1'b0;

        for (int i = 1; i < 32; i++) begin
            fill[i] = {i[7:0], ~i[7:0], 8'h3C, i[7:0] ^ 8'hA5};
            wr(5'(i), fill[i]);
        end
        for (int i = 1; i < 32; i++) begin
            rd("fill", 5'(i), 5'(32 - i), fill[i], fill[32 - i]);
        end

        rs1_addr = 5'd1;
        rs2_addr = 5'd31;
        @(posedge clk_core);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rs1", rs1_data, 32'h0);
        chk("arst_rs2", rs2_data, 32'h0);
        wr_en = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h9999_9999;
        @(negedge clk_core);
        @(negedge clk_core);
        wr_en = 1'b0;
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rd("post_rst", 5'(i), 5'(32 - i), 32'h0, 32'h0);
        end

        wr(5'd9, 32'h0BAD_F00D);
        rd("rewrite", 5'd9, 5'd8, 32'h0BAD_F00D, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
